// File: rtl/trace_monitor_pkg.sv
// Shared constants and event payload for the trace nop monitor.
package trace_monitor_pkg;

  localparam logic [7:0]  NOP_OPCODE = 8'h15;
  localparam logic [15:0] NOP_EXIT   = 16'h0001;
  localparam logic [15:0] NOP_REPORT = 16'h0002;
  localparam logic [15:0] NOP_PUTC   = 16'h0004;

  // "time" is reserved in SystemVerilog, so the timestamp field is named stamp.
  typedef struct packed {
    logic [15:0] code;
    logic [31:0] pc;
    logic [31:0] r3;
    logic [31:0] stamp;
  } trace_event_t;

  function automatic logic is_sim_nop(input logic [31:0] insn);
    return (insn[31:24] == NOP_OPCODE) && (insn[15:0] != 16'h0000);
  endfunction

endpackage

// File: rtl/trace_nop_monitor_if.sv
// Trace input bus and event valid/ready channel; master is the monitor side.
interface trace_nop_monitor_if;
  logic        trace_enable;
  logic [31:0] trace_pc;
  logic [31:0] trace_insn;
  logic        trace_wben;
  logic [4:0]  trace_wbreg;
  logic [31:0] trace_wbdata;
  logic        event_valid;
  logic        event_ready;
  logic [15:0] event_code;
  logic [31:0] event_pc;
  logic [31:0] event_r3;
  logic [31:0] event_time;

  modport master (
    input  trace_enable, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
    input  event_ready,
    output event_valid, event_code, event_pc, event_r3, event_time
  );

  modport slave (
    output trace_enable, trace_pc, trace_insn, trace_wben, trace_wbreg, trace_wbdata,
    output event_ready,
    input  event_valid, event_code, event_pc, event_r3, event_time
  );
endinterface

// File: rtl/trace_event_fifo.sv
// Event FIFO with extended-pointer full/empty; head is presented combinationally.
module trace_event_fifo
  import trace_monitor_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_sys,
  input  logic         push,
  input  trace_event_t wdata,
  output logic         full,
  input  logic         pop,
  output logic         empty,
  output trace_event_t rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wptr_r;
  logic [AW:0]  rptr_r;
  trace_event_t mem_r [DEPTH];
  logic         pop_ok_s;
  logic         push_ok_s;

  assign empty     = (wptr_r == rptr_r);
  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Pointer update; a push into a full FIFO reuses the slot being popped.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_ok_s)  rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Payload storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wptr_r[AW-1:0]] <= wdata;
  end

  // Head entry, forced to zero while empty so stale data never shows.
  always_comb begin
    rdata = '0;
    if (!empty) rdata = mem_r[rptr_r[AW-1:0]];
    else        rdata = '0;
  end

endmodule

// File: rtl/trace_nop_monitor.sv
// Trace nop monitor top: r3 shadow, nop decode, sticky flags, event FIFO.
// Optional per-event cycle timestamp with TRACE_NOP_MONITOR_TIMESTAMP_EN.
module trace_nop_monitor
  import trace_monitor_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_sys,
  trace_nop_monitor_if.master       bus,
  output logic [31:0]               r3,
  output logic                      terminated,
  output logic                      overflow
);

  logic [31:0]  r3_r;
  logic         terminated_r;
  logic         overflow_r;
  logic         full_s;
  logic         empty_s;
  logic         detect_s;
  logic         accept_s;
  logic         pop_s;
  logic         push_s;
  logic         drop_s;
  logic [31:0]  stamp_s;
  trace_event_t wdata_s;
  trace_event_t head_s;

`ifdef TRACE_NOP_MONITOR_TIMESTAMP_EN
  logic [31:0] cycle_cnt_r;

  // Free-running cycle counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst_sys) cycle_cnt_r <= 32'h0000_0000;
    else         cycle_cnt_r <= cycle_cnt_r + 32'h0000_0001;
  end

  assign stamp_s = cycle_cnt_r;
`else
  assign stamp_s = 32'h0000_0000;
`endif

  // Decode and push/drop decisions; events after exit are ignored silently.
  always_comb begin
    detect_s      = bus.trace_enable && is_sim_nop(bus.trace_insn);
    accept_s      = detect_s && !terminated_r;
    pop_s         = !empty_s && bus.event_ready;
    push_s        = accept_s && (!full_s || pop_s);
    drop_s        = accept_s && full_s && !pop_s;
    wdata_s.code  = bus.trace_insn[15:0];
    wdata_s.pc    = bus.trace_pc;
    wdata_s.r3    = r3_r;
    wdata_s.stamp = stamp_s;
  end

  // r3 shadow and sticky flags.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      r3_r         <= 32'h0000_0000;
      terminated_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      if (bus.trace_enable && bus.trace_wben && (bus.trace_wbreg == 5'd3))
        r3_r <= bus.trace_wbdata;
      if (accept_s && (bus.trace_insn[15:0] == NOP_EXIT))
        terminated_r <= 1'b1;
      if (drop_s)
        overflow_r <= 1'b1;
    end
  end

  trace_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_sys (rst_sys),
    .push    (push_s),
    .wdata   (wdata_s),
    .full    (full_s),
    .pop     (pop_s),
    .empty   (empty_s),
    .rdata   (head_s)
  );

  assign bus.event_valid = !empty_s;
  assign bus.event_code  = head_s.code;
  assign bus.event_pc    = head_s.pc;
  assign bus.event_r3    = head_s.r3;
  assign bus.event_time  = head_s.stamp;
  assign r3              = r3_r;
  assign terminated      = terminated_r;
  assign overflow        = overflow_r;

endmodule

// File: tb/tb_trace_nop_monitor.sv
// Directed self-checking bench for trace_nop_monitor (FIFO_DEPTH = 8).
module tb_trace_nop_monitor;
  import trace_monitor_pkg::*;

  logic        clk;
  logic        rst_sys;
  logic [31:0] r3;
  logic        terminated;
  logic        overflow;
  int          n_cmp;
  int          n_err;

  trace_nop_monitor_if bus ();

  trace_nop_monitor #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst_sys    (rst_sys),
    .bus        (bus),
    .r3         (r3),
    .terminated (terminated),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_sys = 1'b1;
    idle();
    rst_sys = 1'b0;
  endtask

  // One retired instruction for one cycle.
  task automatic retire(input logic [31:0] pc, input logic [31:0] insn,
                        input logic wben, input logic [4:0] wbreg, input logic [31:0] wbdata);
    bus.trace_enable = 1'b1;
    bus.trace_pc     = pc;
    bus.trace_insn   = insn;
    bus.trace_wben   = wben;
    bus.trace_wbreg  = wbreg;
    bus.trace_wbdata = wbdata;
    idle();
    bus.trace_enable = 1'b0;
    bus.trace_wben   = 1'b0;
  endtask

  task automatic nop(input logic [31:0] pc, input logic [15:0] k);
    logic [31:0] insn;
    insn = {NOP_OPCODE, 8'h00, k};
    retire(pc, insn, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic pop_one();
    bus.event_ready = 1'b1;
    idle();
    bus.event_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_sys = 1'b1;
    bus.trace_enable = 1'b0;
    bus.trace_pc     = 32'h0;
    bus.trace_insn   = 32'h0;
    bus.trace_wben   = 1'b0;
    bus.trace_wbreg  = 5'd0;
    bus.trace_wbdata = 32'h0;
    bus.event_ready  = 1'b0;
    idle();
    do_reset();

    chk("rst_valid", {31'h0, bus.event_valid}, 32'h0);
    chk("rst_r3", r3, 32'h0);
    chk("rst_term", {31'h0, terminated}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);
    chk("rst_code", {16'h0, bus.event_code}, 32'h0);
    chk("rst_pc", bus.event_pc, 32'h0);
    chk("rst_evr3", bus.event_r3, 32'h0);
    chk("rst_time", bus.event_time, 32'h0);

    // addi r3 then l.nop 0x2 at 0x100
    retire(32'h0000_00fc, 32'h9c60_1234, 1'b1, 5'd3, 32'h0000_1234);
    chk("addi_r3", r3, 32'h0000_1234);
    chk("addi_novalid", {31'h0, bus.event_valid}, 32'h0);
    nop(32'h0000_0100, NOP_REPORT);
    chk("rep_valid", {31'h0, bus.event_valid}, 32'h1);
    chk("rep_code", {16'h0, bus.event_code}, 32'h2);
    chk("rep_pc", bus.event_pc, 32'h0000_0100);
    chk("rep_r3", bus.event_r3, 32'h0000_1234);
    idle();
    chk("rep_stable", bus.event_pc, 32'h0000_0100);
    pop_one();
    chk("rep_popped", {31'h0, bus.event_valid}, 32'h0);

    // r3 written the cycle before the nop; then plain nop 0 while popping
    retire(32'h0000_01fc, 32'h9c60_0055, 1'b1, 5'd3, 32'h0000_0055);
    nop(32'h0000_0200, NOP_PUTC);
    chk("putc_code", {16'h0, bus.event_code}, 32'h4);
    chk("putc_r3", bus.event_r3, 32'h0000_0055);
    bus.event_ready = 1'b1;
    nop(32'h0000_0204, 16'h0000);
    bus.event_ready = 1'b0;
    chk("nop0_noevent", {31'h0, bus.event_valid}, 32'h0);

    // 9 nops into a depth-8 FIFO: last one dropped
    for (int i = 0; i < 9; i++) nop(32'h0000_0300 + 32'(4 * i), NOP_PUTC);
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("ovf_code", {16'h0, bus.event_code}, 32'h4);
      chk("ovf_pc", bus.event_pc, 32'h0000_0300 + 32'(4 * i));
      pop_one();
    end
    chk("ovf_drained", {31'h0, bus.event_valid}, 32'h0);

    // full FIFO, push with a same-cycle pop is accepted
    do_reset();
    for (int i = 0; i < 8; i++) nop(32'h0000_0400 + 32'(4 * i), NOP_PUTC);
    chk("full_noovf", {31'h0, overflow}, 32'h0);
    bus.event_ready = 1'b1;
    nop(32'h0000_0500, NOP_REPORT);
    bus.event_ready = 1'b0;
    chk("pp_noovf", {31'h0, overflow}, 32'h0);
    for (int i = 1; i < 8; i++) begin
      chk("pp_pc", bus.event_pc, 32'h0000_0400 + 32'(4 * i));
      pop_one();
    end
    chk("pp_last_pc", bus.event_pc, 32'h0000_0500);
    chk("pp_last_code", {16'h0, bus.event_code}, 32'h2);
    pop_one();
    chk("pp_empty", {31'h0, bus.event_valid}, 32'h0);

    // exit nop, then a later event is silently dropped
    nop(32'h0000_0600, NOP_EXIT);
    chk("exit_term", {31'h0, terminated}, 32'h1);
    chk("exit_code", {16'h0, bus.event_code}, 32'h1);
    chk("exit_r3", bus.event_r3, 32'h0);
    nop(32'h0000_0604, NOP_REPORT);
    pop_one();
    chk("post_exit_empty", {31'h0, bus.event_valid}, 32'h0);
    chk("post_exit_noovf", {31'h0, overflow}, 32'h0);

    // reset mid-operation with queued events and terminated set
    do_reset();
    retire(32'h0000_06fc, 32'h9c60_0099, 1'b1, 5'd3, 32'h0000_0099);
    nop(32'h0000_0700, NOP_REPORT);
    nop(32'h0000_0704, NOP_REPORT);
    nop(32'h0000_0708, NOP_EXIT);
    chk("pre_rst_term", {31'h0, terminated}, 32'h1);
    do_reset();
    chk("mid_rst_valid", {31'h0, bus.event_valid}, 32'h0);
    chk("mid_rst_term", {31'h0, terminated}, 32'h0);
    chk("mid_rst_ovf", {31'h0, overflow}, 32'h0);
    chk("mid_rst_r3", r3, 32'h0);

    // nop in the 10th cycle after reset release
    repeat (10) idle();
    nop(32'h0000_0800, NOP_REPORT);
    chk("ts_valid", {31'h0, bus.event_valid}, 32'h1);
`ifdef TRACE_NOP_MONITOR_TIMESTAMP_EN
    chk("ts_time", bus.event_time, 32'd10);
`else
    chk("ts_time", bus.event_time, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
